// File: rtl/output_argmax_scorer_pkg.sv
// output_argmax_scorer_pkg: shared width helpers and FSM state encodings
package output_argmax_scorer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  // Signed output-element width of a layer fed by np neurons of wv-bit values
  function automatic int f_wo(input int np, input int wv);
    return $clog2(np) + 1 + wv;
  endfunction
  // Class index width, at least one bit
  function automatic int f_wl(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction
endpackage

// File: rtl/output_argmax_scorer_if.sv
// output_argmax_scorer_if: output-vector, label and result handshakes of the scorer
interface output_argmax_scorer_if #(parameter int WO = 9, parameter int WL = 3, parameter int NC = 6);
  logic             iValid_AM_Output;
  logic             oReady_AM_Output;
  logic [NC*WO-1:0] iData_AM_Output;
  logic             iValid_AS_Label;
  logic             oReady_AS_Label;
  logic [WL-1:0]    iData_AS_Label;
  logic             oValid_BM_Result;
  logic             iReady_BM_Result;
  logic [WL-1:0]    oData_BM_Result;
  modport slave (
    input  iValid_AM_Output, iData_AM_Output, iValid_AS_Label, iData_AS_Label, iReady_BM_Result,
    output oReady_AM_Output, oReady_AS_Label, oValid_BM_Result, oData_BM_Result
  );
  modport master (
    output iValid_AM_Output, iData_AM_Output, iValid_AS_Label, iData_AS_Label, iReady_BM_Result,
    input  oReady_AM_Output, oReady_AS_Label, oValid_BM_Result, oData_BM_Result
  );
endinterface

// File: rtl/output_argmax_scorer_sat_counter.sv
// sat_counter: saturating up-counter with clear taking priority over increment
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  // Count up on inc, stick at all-ones, clear wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/output_argmax_scorer.sv
// output_argmax_scorer: joins output vector with label, finds arg-max class, keeps accuracy counters
module output_argmax_scorer
  import output_argmax_scorer_pkg::*;
#(
  parameter int NP   = 7,
  parameter int NC   = 6,
  parameter int WV   = 5,
  parameter int WCNT = 16
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iClear,
  output_argmax_scorer_if.slave        bus,
  output logic                         oHit,
  output logic [WCNT-1:0]              oTotal,
  output logic [WCNT-1:0]              oCorrect
);
  localparam int WO = f_wo(NP, WV);
  localparam int WL = f_wl(NC);
  state_t                  r_state;
  logic                    r_live, r_have_vec, r_have_lbl, r_valid, r_hit;
  logic [NC*WO-1:0]        r_vec;
  logic [WL-1:0]           r_lbl, r_i, r_idx;
  logic signed [WO-1:0]    r_best;
  logic signed [WO-1:0]    w_elem;
  logic                    w_xfer_vec, w_xfer_lbl, w_gt, w_last, w_hs;
  logic [WL-1:0]           w_next_idx;
  // A label outside the class range can never match a predicted index
  function automatic logic f_hit(input logic [WL-1:0] lbl, input logic [WL-1:0] idx);
    return (lbl == idx) && (int'(lbl) < NC);
  endfunction
  assign bus.oReady_AM_Output = r_live && (r_state == IDLE) && !r_have_vec;
  assign bus.oReady_AS_Label  = r_live && (r_state == IDLE) && !r_have_lbl;
  assign bus.oValid_BM_Result = r_valid;
  assign bus.oData_BM_Result  = r_idx;
  assign oHit                 = r_hit;
  assign w_xfer_vec = bus.iValid_AM_Output && bus.oReady_AM_Output;
  assign w_xfer_lbl = bus.iValid_AS_Label && bus.oReady_AS_Label;
  assign w_elem     = $signed(r_vec[r_i*WO +: WO]);
  assign w_gt       = w_elem > r_best;
  assign w_next_idx = w_gt ? r_i : r_idx;
  assign w_last     = r_i == WL'(NC - 1);
  assign w_hs       = r_valid && bus.iReady_BM_Result;
  // Capture both inputs, scan one element per cycle, hold the result until accepted
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state    <= IDLE;
      r_live     <= 1'b0;
      r_have_vec <= 1'b0;
      r_have_lbl <= 1'b0;
      r_valid    <= 1'b0;
      r_hit      <= 1'b0;
      r_vec      <= '0;
      r_lbl      <= '0;
      r_i        <= '0;
      r_idx      <= '0;
      r_best     <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_xfer_vec) begin
            r_vec      <= bus.iData_AM_Output;
            r_have_vec <= 1'b1;
          end
          if (w_xfer_lbl) begin
            r_lbl      <= bus.iData_AS_Label;
            r_have_lbl <= 1'b1;
          end
          if (r_have_vec && r_have_lbl) begin
            r_idx <= '0;
            if (NC == 1) begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_hit   <= f_hit(r_lbl, '0);
            end else begin
              r_state <= SCAN;
              r_best  <= $signed(r_vec[WO-1:0]);
              r_i     <= WL'(1);
            end
          end
        end
        SCAN: begin
          if (w_gt) begin
            r_best <= w_elem;
            r_idx  <= r_i;
          end
          r_i <= r_i + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_hit   <= f_hit(r_lbl, w_next_idx);
          end
        end
        DONE: begin
          if (w_hs) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_hit      <= 1'b0;
            r_have_vec <= 1'b0;
            r_have_lbl <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  sat_counter #(.W(WCNT)) u_total (
    .clk(iCLK), .rst_n(iRST), .clr(iClear), .inc(w_hs), .q(oTotal)
  );
  sat_counter #(.W(WCNT)) u_correct (
    .clk(iCLK), .rst_n(iRST), .clr(iClear), .inc(w_hs && r_hit), .q(oCorrect)
  );
endmodule

// File: tb/tb_output_argmax_scorer.sv
// tb_output_argmax_scorer: directed checks of arg-max scoring, handshakes and counters
module tb_output_argmax_scorer;
  localparam int NP = 7, NC = 6, WV = 5, WCNT = 4, WO = 9, WL = 3;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            hit;
  logic [WCNT-1:0] tot, cor;
  int              checks = 0;
  int              errs = 0;
  int              n;
  output_argmax_scorer_if #(.WO(WO), .WL(WL), .NC(NC)) ifc ();
  output_argmax_scorer #(.NP(NP), .NC(NC), .WV(WV), .WCNT(WCNT)) u_dut (
    .iCLK(clk), .iRST(rst_n), .iClear(clr), .bus(ifc.slave),
    .oHit(hit), .oTotal(tot), .oCorrect(cor)
  );
  always #5 clk = ~clk;
  function automatic logic [NC*WO-1:0] pack(input int a, input int b, input int c, input int d, input int e, input int f);
    int t[6];
    logic [NC*WO-1:0] v;
    t = '{a, b, c, d, e, f};
    v = '0;
    for (int k = 0; k < 6; k++) v[k*WO +: WO] = WO'(t[k]);
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic send(input int a, input int b, input int c, input int d, input int e, input int f, input int lbl);
    ifc.iData_AM_Output  = pack(a, b, c, d, e, f);
    ifc.iData_AS_Label   = WL'(lbl);
    ifc.iValid_AM_Output = 1'b1;
    ifc.iValid_AS_Label  = 1'b1;
    @(posedge clk);
    #1;
    ifc.iValid_AM_Output = 1'b0;
    ifc.iValid_AS_Label  = 1'b0;
  endtask
  task automatic wait_valid(input int lim, output int cnt);
    cnt = 0;
    while (!ifc.oValid_BM_Result && cnt < lim) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask
  task automatic handshake();
    ifc.iReady_BM_Result = 1'b1;
    @(posedge clk);
    #1;
    ifc.iReady_BM_Result = 1'b0;
  endtask
  initial begin
    ifc.iValid_AM_Output = 1'b0;
    ifc.iValid_AS_Label  = 1'b0;
    ifc.iReady_BM_Result = 1'b0;
    ifc.iData_AM_Output  = '0;
    ifc.iData_AS_Label   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ifc.oValid_BM_Result), 0);
    chk("rst_rdy_vec", 32'(ifc.oReady_AM_Output), 0);
    chk("rst_total", 32'(tot), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_rdy_vec", 32'(ifc.oReady_AM_Output), 1);
    chk("idle_rdy_lbl", 32'(ifc.oReady_AS_Label), 1);
    send(-3, 10, 4, 10, -256, 0, 1);
    chk("t1_rdy_vec", 32'(ifc.oReady_AM_Output), 0);
    chk("t1_rdy_lbl", 32'(ifc.oReady_AS_Label), 0);
    wait_valid(20, n);
    chk("t1_latency", n, 6);
    chk("t1_data", 32'(ifc.oData_BM_Result), 1);
    chk("t1_hit", 32'(hit), 1);
    chk("t1_total_pre", 32'(tot), 0);
    handshake();
    chk("t1_valid_drop", 32'(ifc.oValid_BM_Result), 0);
    chk("t1_total", 32'(tot), 1);
    chk("t1_correct", 32'(cor), 1);
    ifc.iData_AS_Label  = 3'd5;
    ifc.iValid_AS_Label = 1'b1;
    @(posedge clk);
    #1;
    ifc.iValid_AS_Label = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_rdy_lbl", 32'(ifc.oReady_AS_Label), 0);
    chk("t2_rdy_vec", 32'(ifc.oReady_AM_Output), 1);
    chk("t2_no_valid", 32'(ifc.oValid_BM_Result), 0);
    ifc.iData_AM_Output  = pack(1, -2, 3, -4, 5, 6);
    ifc.iValid_AM_Output = 1'b1;
    @(posedge clk);
    #1;
    ifc.iValid_AM_Output = 1'b0;
    wait_valid(20, n);
    chk("t2_latency", n, 6);
    chk("t2_data", 32'(ifc.oData_BM_Result), 5);
    chk("t2_hit", 32'(hit), 1);
    handshake();
    repeat (8) @(posedge clk);
    #1;
    chk("t2_once", 32'(ifc.oValid_BM_Result), 0);
    chk("t2_total", 32'(tot), 2);
    chk("t2_correct", 32'(cor), 2);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_total", 32'(tot), 0);
    chk("clr_correct", 32'(cor), 0);
    send(-256, -256, -256, -256, -256, -256, 5);
    wait_valid(20, n);
    chk("t3_data", 32'(ifc.oData_BM_Result), 0);
    chk("t3_hit", 32'(hit), 0);
    handshake();
    chk("t3_total", 32'(tot), 1);
    chk("t3_correct", 32'(cor), 0);
    send(0, 0, 0, 0, 7, -1, 4);
    wait_valid(20, n);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_data", 32'(ifc.oData_BM_Result), 4);
      chk("bp_hit", 32'(hit), 1);
      chk("bp_rdy", 32'({ifc.oReady_AM_Output, ifc.oReady_AS_Label}), 0);
      chk("bp_total", 32'(tot), 1);
    end
    handshake();
    chk("bp_total_post", 32'(tot), 2);
    chk("bp_correct_post", 32'(cor), 1);
    send(-3, 10, 4, 10, -256, 0, 6);
    wait_valid(20, n);
    chk("oor_data", 32'(ifc.oData_BM_Result), 1);
    chk("oor_hit", 32'(hit), 0);
    handshake();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(0, 0, 0, 0, 0, 9, 5);
      wait_valid(20, n);
      handshake();
    end
    chk("sat_total", 32'(tot), 15);
    chk("sat_correct", 32'(cor), 15);
    send(0, 0, 0, 0, 0, 9, 5);
    wait_valid(20, n);
    chk("sat_valid", 32'(ifc.oValid_BM_Result), 1);
    clr = 1'b1;
    ifc.iReady_BM_Result = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    ifc.iReady_BM_Result = 1'b0;
    chk("clrhs_total", 32'(tot), 0);
    chk("clrhs_correct", 32'(cor), 0);
    chk("clrhs_valid", 32'(ifc.oValid_BM_Result), 0);
    send(0, 0, 0, 0, 0, 9, 5);
    wait_valid(20, n);
    handshake();
    chk("pre_rst_total", 32'(tot), 1);
    send(0, 9, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ifc.oValid_BM_Result), 0);
    chk("mid_rst_total", 32'(tot), 0);
    chk("mid_rst_correct", 32'(cor), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(-3, 10, 4, 10, -256, 0, 3);
    wait_valid(20, n);
    chk("post_rst_latency", n, 6);
    chk("post_rst_data", 32'(ifc.oData_BM_Result), 1);
    chk("post_rst_hit", 32'(hit), 0);
    handshake();
    chk("post_rst_total", 32'(tot), 1);
    chk("post_rst_correct", 32'(cor), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
